alu_arbiter: RTL
================

# alu_arbiter

Shares one 4-bit ALU datapath between two requesters using a req/grant/done handshake. The block arbitrates round-robin, latches the winner's operands and function select, and executes the operation. It registers the 8-bit result and drives two 7-segment digits showing that result. It sits between board-level requester logic (switch/key front ends or sequencers) and the existing ALU function set.

## Interface
- No parameters; widths fixed (4-bit operands, 3-bit select, 8-bit result).
- clock  input  1  rising-edge system clock
- resetn  input  1  asynchronous, active-low reset
- req  input  2  request per requester (bit 0 = requester 0)
- a0, b0  input  4 each  requester 0 operands
- sel0  input  3  requester 0 function select
- a1, b1  input  4 each  requester 1 operands
- sel1  input  3  requester 1 function select
- gnt  output  2  one-hot grant; at most one bit high
- busy  output  1  high in EXEC and DONE
- done  output  1  one-cycle completion pulse for the granted requester
- result  output  8  registered ALU result of the last completed operation
- hex_lo  output  7  active-low 7-segment code of result[3:0]
- hex_hi  output  7  active-low 7-segment code of result[7:4]

## Operation
- FSM states:
  - IDLE: if req != 0 at a rising edge, pick the winner, latch its a/b/sel into internal registers, set gnt[winner], go to EXEC.
  - EXEC: compute the ALU function on the latched operands, load result, assert done, go to DONE.
  - DONE: clear done and gnt, update the last-grant pointer, go to IDLE.
- Arbitration (default): a single active request wins. When both are active, the requester not granted last wins. After reset, the pointer favours requester 0.
- ALU functions on latched A, B:
  - 000: {3'b0, 5-bit A+B with carry in bit 4}
  - 001: A+B zero-extended to 8 bits
  - 010: {A^B, A|B}
  - 011: 8'h81 if any bit of A or B is 1, else 8'h00
  - 100: 8'h7E if all bits of A and B are 1, else 8'h00
  - 101: {~A, B}
  - 110/111: 8'h00
- Unused select codes still complete normally: result 8'h00, done pulses.
- Inputs changing while busy are ignored; operands are latched only in IDLE.
- req held high through DONE is treated as a new request at the next IDLE sample.
- hex_lo and hex_hi are combinational decodes of result using the team's 4-bit hex decoder.

## Timing
- A request sampled at edge k:
  - gnt valid after edge k
  - result and done valid after edge k+1
  - done and gnt low after edge k+2
  - earliest next grant at edge k+3
- Throughput: one operation per 3 cycles.
- done is high for exactly one cycle. gnt is high for two cycles and overlaps done.
- result holds its value until the next EXEC.
- Reset values: gnt=2'b00, done=0, busy=0, result=8'h00, hex_lo=hex_hi=7'b1000000 ("0"), FSM=IDLE, pointer favours requester 0.
- resetn asserted mid-operation: all outputs go to reset values immediately. The operation is abandoned and no done is issued.
- req deasserted during EXEC: the operation still completes and done still pulses.

## Configuration
- ALU_ARB_FIXED_PRI_EN
  - Defined: fixed priority; requester 0 always wins a simultaneous request, and the pointer logic is removed.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then req=01, a0=4'h9, b0=4'h8, sel0=000 → gnt=01 after edge 1; done=1 and result=8'h11 after edge 2; hex_hi=digit 1, hex_lo=digit 1.
- req=11 held continuously, sel0=010 (a0=3, b0=5), sel1=101 (a1=4'hF, b1=4'h2) → grants alternate 01,10,01; results 8'h67, 8'h02, 8'h67; each done one cycle wide, 3 cycles apart. With ALU_ARB_FIXED_PRI_EN defined: gnt=01 every time.
- sel=011 with A=B=0 → 8'h00; A=0, B=4'h1 → 8'h81. sel=100 with A=B=4'hF → 8'h7E; A=4'hE, B=4'hF → 8'h00.
- sel=111 → result=8'h00, done still pulses; then a req=01 operation whose a0 changes during EXEC → result uses the value latched at the grant edge.
- Assert resetn=0 during EXEC → done never pulses; result=8'h00, gnt=00, busy=0 immediately (asynchronous).

Source files
------------

// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module      : alu_arbiter_if
// Description : Request/grant/done bundle between two requesters and the
//               shared 4-bit ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if;
    logic [1:0] req;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [2:0] sel0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [2:0] sel1;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [6:0] hex_lo;
    logic [6:0] hex_hi;

    // Requester side
    modport master (
        output req, a0, b0, sel0, a1, b1, sel1,
        input  gnt, busy, done, result, hex_lo, hex_hi
    );

    // Arbiter side
    modport slave (
        input  req, a0, b0, sel0, a1, b1, sel1,
        output gnt, busy, done, result, hex_lo, hex_hi
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one 4-bit ALU between two
//               requesters; registered 8-bit result with 7-segment decode.
//               Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter (
    input  wire           clock,
    input  wire           resetn,
    alu_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_win;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [2:0] r_sel;
    logic [7:0] r_result;
    logic       w_win;
    logic [7:0] w_alu;
    logic       w_start;

    assign w_start = (r_state == S_IDLE) && (bus.req != 2'b00);

`ifdef ALU_ARB_FIXED_PRI_EN
    assign w_win = ~bus.req[0];
`else
    // Pointer holds the last winner; reset value 1 lets requester 0 win first.
    logic r_last;
    assign w_win = (bus.req == 2'b11) ? ~r_last : bus.req[1];
`endif

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        w_alu = 8'h00;
        case (r_sel)
            3'b000,
            3'b001:  w_alu = {3'b000, {1'b0, r_a} + {1'b0, r_b}};
            3'b010:  w_alu = {r_a ^ r_b, r_a | r_b};
            3'b011:  w_alu = (|{r_a, r_b}) ? 8'h81 : 8'h00;
            3'b100:  w_alu = (&{r_a, r_b}) ? 8'h7E : 8'h00;
            3'b101:  w_alu = {~r_a, r_b};
            default: w_alu = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start ? S_EXEC : S_IDLE;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.gnt  = 2'b00;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        if (r_state == S_EXEC || r_state == S_DONE) begin
            bus.gnt  = r_win ? 2'b10 : 2'b01;
            bus.busy = 1'b1;
        end
        if (r_state == S_DONE) begin
            bus.done = 1'b1;
        end
    end

    // Operand latch, result register and grant pointer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_win    <= 1'b0;
            r_a      <= 4'h0;
            r_b      <= 4'h0;
            r_sel    <= 3'b000;
            r_result <= 8'h00;
`ifndef ALU_ARB_FIXED_PRI_EN
            r_last   <= 1'b1;
`endif
        end else begin
            if (w_start) begin
                r_win <= w_win;
                r_a   <= w_win ? bus.a1   : bus.a0;
                r_b   <= w_win ? bus.b1   : bus.b0;
                r_sel <= w_win ? bus.sel1 : bus.sel0;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_alu;
            end
`ifndef ALU_ARB_FIXED_PRI_EN
            if (r_state == S_DONE) begin
                r_last <= r_win;
            end
`endif
        end
    end

    assign bus.result = r_result;
    assign bus.hex_lo = hex_seg(r_result[3:0]);
    assign bus.hex_hi = hex_seg(r_result[7:4]);

endmodule

`default_nettype wire
